id_ex_stage: RTL and testbench

ID/EX pipeline stage register for the MIPS datapath. It sits directly downstream of the main control unit and the register file. Each cycle it captures the decoded control bits (reg_dst, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write), the operand data and the register addresses, and presents them registered to the EX stage. It detects load-use hazards against the instruction it currently holds and inserts a single bubble. It supports downstream back-pressure and a flush from branch resolution.

---
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the MIPS datapath.
// Captures decoded control, operands and register addresses from ID,
// inserts a single bubble on a load-use dependency, honours EX
// back-pressure and a branch flush.
// Build option: define ID_EX_STALL_CNT_EN to build the hazard bubble
// counter on stall_count; otherwise stall_count is tied to zero.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reg_dst,
    input  logic                  branch,
    input  logic                  mem_read,
    input  logic                  mem_to_reg,
    input  logic                  mem_write,
    input  logic                  alu_src,
    input  logic                  reg_write,
    input  logic [1:0]            alu_op,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [DATA_W-1:0]     imm,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  ex_valid,
    output logic                  ex_reg_dst,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic [1:0]            ex_alu_op,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs_addr,
    output logic [REG_ADDR_W-1:0] ex_rt_addr,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  hazard,
    output logic [15:0]           stall_count
);

    typedef struct packed {
        logic                  reg_dst;
        logic                  branch;
        logic                  mem_read;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
        logic [1:0]            alu_op;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
    } id_ex_t;

    id_ex_t id_d;
    id_ex_t ex_q;
    logic   ex_vld_q;
    logic   uses_rt;
    logic   advance;

    // Pack the ID-side fields so the register update is a single assignment.
    always_comb begin
        id_d = '{reg_dst: reg_dst, branch: branch, mem_read: mem_read,
                 mem_to_reg: mem_to_reg, mem_write: mem_write,
                 alu_src: alu_src, reg_write: reg_write, alu_op: alu_op,
                 rs_data: rs_data, rt_data: rt_data, imm: imm,
                 rs_addr: rs_addr, rt_addr: rt_addr, rd_addr: rd_addr};
    end

    // Load-use detection against the held load; $zero never conflicts.
    // Only R-type, store and branch actually read rt as a source.
    always_comb begin
        uses_rt  = reg_dst | mem_write | branch;
        hazard   = in_valid & ex_vld_q & ex_q.mem_read & (ex_q.rt_addr != '0) &
                   ((ex_q.rt_addr == rs_addr) | (uses_rt & (ex_q.rt_addr == rt_addr)));
        advance  = !ex_vld_q | out_ready;
        in_ready = !rst & !flush & !hazard & advance;
    end

    // Stage register: flush beats back-pressure, which beats hazard bubbles.
    // Bubbles clear the whole bundle so EX never sees stale control bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= '0;
            ex_vld_q <= 1'b0;
        end else if (flush) begin
            ex_q     <= '0;
            ex_vld_q <= 1'b0;
        end else if (!advance) begin
            ex_q     <= ex_q;
            ex_vld_q <= ex_vld_q;
        end else if (hazard) begin
            ex_q     <= '0;
            ex_vld_q <= 1'b0;
        end else if (in_valid) begin
            ex_q     <= id_d;
            ex_vld_q <= 1'b1;
        end else begin
            ex_q     <= '0;
            ex_vld_q <= 1'b0;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Count hazard bubbles only; holds and flushes do not count. Saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (!flush && advance && hazard && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

    assign ex_valid      = ex_vld_q;
    assign ex_reg_dst    = ex_q.reg_dst;
    assign ex_branch     = ex_q.branch;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_rs_data    = ex_q.rs_data;
    assign ex_rt_data    = ex_q.rt_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs_addr    = ex_q.rs_addr;
    assign ex_rt_addr    = ex_q.rt_addr;
    assign ex_rd_addr    = ex_q.rd_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: accepted instructions are queued when
// driven and compared when they appear on the ex_* outputs one edge later.
module tb_id_ex_stage;

    typedef struct packed {
        logic        reg_dst;
        logic        branch;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic [1:0]  alu_op;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
    } instr_t;

    localparam int BUB  = 0;
    localparam int LOAD = 1;
    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_ready;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic        ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
    logic        hazard;
    logic [15:0] stall_count;

    int     vectors = 0;
    int     miscompares = 0;
    int     exp_stall = 0;
    instr_t sb_q[$];
    instr_t last_exp;
    logic   last_vld;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .alu_op(alu_op), .rs_data(rs_data),
        .rt_data(rt_data), .imm(imm), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .flush(flush), .out_ready(out_ready),
        .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_rd_addr(ex_rd_addr), .hazard(hazard), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic instr_t ex_bundle();
        instr_t b;
        b = '{reg_dst: ex_reg_dst, branch: ex_branch, mem_read: ex_mem_read,
              mem_to_reg: ex_mem_to_reg, mem_write: ex_mem_write,
              alu_src: ex_alu_src, reg_write: ex_reg_write, alu_op: ex_alu_op,
              rs_data: ex_rs_data, rt_data: ex_rt_data, imm: ex_imm,
              rs_addr: ex_rs_addr, rt_addr: ex_rt_addr, rd_addr: ex_rd_addr};
        return b;
    endfunction

    function automatic instr_t rtype(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [31:0] rsd,
                                     input logic [31:0] rtd);
        instr_t i;
        i = '0;
        i.reg_dst = 1'b1; i.reg_write = 1'b1; i.alu_op = 2'b10;
        i.rs_addr = rs; i.rt_addr = rt; i.rd_addr = rd;
        i.rs_data = rsd; i.rt_data = rtd;
        return i;
    endfunction

    function automatic instr_t lw(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [31:0] off);
        instr_t i;
        i = '0;
        i.mem_read = 1'b1; i.mem_to_reg = 1'b1; i.alu_src = 1'b1; i.reg_write = 1'b1;
        i.rs_addr = rs; i.rt_addr = rt; i.imm = off; i.rs_data = 32'h1000;
        return i;
    endfunction

    task automatic drive(input instr_t i, input logic iv, input logic fl, input logic ordy);
        {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write} =
            {i.reg_dst, i.branch, i.mem_read, i.mem_to_reg, i.mem_write, i.alu_src, i.reg_write};
        alu_op = i.alu_op; rs_data = i.rs_data; rt_data = i.rt_data; imm = i.imm;
        rs_addr = i.rs_addr; rt_addr = i.rt_addr; rd_addr = i.rd_addr;
        in_valid = iv; flush = fl; out_ready = ordy;
    endtask

    // One cycle: drive, check combinational outputs, clock, check the outcome
    // the scenario says should happen (load / bubble / hold).
    task automatic cycle(input string tag, input instr_t i, input logic iv,
                         input logic fl, input logic ordy, input logic exp_haz,
                         input logic exp_rdy, input int res);
        instr_t got, exp;
        @(negedge clk);
        drive(i, iv, fl, ordy);
        #1;
        check({tag, ".hazard"}, 128'(hazard), 128'(exp_haz));
        check({tag, ".in_ready"}, 128'(in_ready), 128'(exp_rdy));
        if (res == LOAD) sb_q.push_back(i);
`ifdef ID_EX_STALL_CNT_EN
        if (res == BUB && exp_haz && !fl) exp_stall++;
`endif
        @(posedge clk);
        #1;
        got = ex_bundle();
        if (res == LOAD) begin
            if (sb_q.size() == 0) begin
                check({tag, ".sb_empty"}, 128'(1), 128'(0));
                exp = '0;
            end else begin
                exp = sb_q.pop_front();
            end
            last_exp = exp; last_vld = 1'b1;
        end else if (res == BUB) begin
            exp = '0; last_exp = '0; last_vld = 1'b0;
        end else begin
            exp = last_exp;
        end
        check({tag, ".ex_valid"}, 128'(ex_valid), 128'(last_vld));
        check({tag, ".ex_bundle"}, 128'(got), 128'(exp));
        check({tag, ".stall_count"}, 128'(stall_count), 128'(exp_stall));
    endtask

    initial begin
        instr_t ra, rb, l1, l3, l4, rc, rd_i, nop;
        ra   = rtype(5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
        rb   = rtype(5'd5, 5'd9, 5'd10, 32'hAAAA_0001, 32'h5555_0002);
        l1   = lw(5'd4, 5'd5, 32'h8);
        l3   = lw(5'd6, 5'd5, 32'hFFFF_FFFC);
        l4   = lw(5'd7, 5'd0, 32'h10);
        rc   = rtype(5'd0, 5'd0, 5'd12, 32'h0, 32'h0);
        rd_i = rtype(5'd13, 5'd14, 5'd15, 32'hDEAD_BEEF, 32'h1234_5678);
        nop  = '0;
        last_exp = '0; last_vld = 1'b0;

        rst = 1'b1;
        drive(nop, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 128'(in_ready), 128'(0));
        check("rst.ex_valid", 128'(ex_valid), 128'(0));
        check("rst.bundle", 128'(ex_bundle()), 128'(0));
        check("rst.stall", 128'(stall_count), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // passthrough
        cycle("pass_r",  ra, 1, 0, 1, 0, 1, LOAD);
        // load-use: one bubble, then dependent accepted
        cycle("lu_lw",   l1, 1, 0, 1, 0, 1, LOAD);
        cycle("lu_haz",  rb, 1, 0, 1, 1, 0, BUB);
        cycle("lu_acc",  rb, 1, 0, 1, 0, 1, LOAD);
        // lw rs=6,rt=5 after lw rt=5: rt not a source, no hazard
        cycle("nh_lw1",  l1, 1, 0, 1, 0, 1, LOAD);
        cycle("nh_lw2",  l3, 1, 0, 1, 0, 1, LOAD);
        // load into $zero never hazards
        cycle("z_lw",    l4, 1, 0, 1, 0, 1, LOAD);
        cycle("z_r",     rc, 1, 0, 1, 0, 1, LOAD);
        // back-pressure for 3 cycles
        cycle("bp0",   rd_i, 1, 0, 0, 0, 0, HOLD);
        cycle("bp1",   rd_i, 1, 0, 0, 0, 0, HOLD);
        cycle("bp2",   rd_i, 1, 0, 0, 0, 0, HOLD);
        cycle("bp_go", rd_i, 1, 0, 1, 0, 1, LOAD);
        // flush with hazard pending: bubble, no stall counted
        cycle("fl_lw",   l1, 1, 0, 1, 0, 1, LOAD);
        cycle("fl_kill", rb, 1, 1, 1, 1, 0, BUB);
        cycle("fl_acc",  rb, 1, 0, 1, 0, 1, LOAD);
        // hazard under back-pressure holds, then bubbles once released
        cycle("hb_lw",   l1, 1, 0, 1, 0, 1, LOAD);
        cycle("hb_hold", rb, 1, 0, 0, 1, 0, HOLD);
        cycle("hb_bub",  rb, 1, 0, 1, 1, 0, BUB);
        cycle("hb_acc",  rb, 1, 0, 1, 0, 1, LOAD);
        // idle slot
        cycle("idle",   nop, 0, 0, 1, 0, 1, BUB);
        // asynchronous reset mid-cycle with a valid instruction held
        cycle("ar_ld",   ra, 1, 0, 0, 0, 1, LOAD);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst.ex_valid", 128'(ex_valid), 128'(0));
        check("arst.bundle", 128'(ex_bundle()), 128'(0));
        check("arst.stall", 128'(stall_count), 128'(0));
        check("arst.in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        check("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
